// File: rtl/button_event_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_decoder_pkg
//  Description : Shared state enumeration and default timing constants for
//                the button event decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_event_decoder_pkg;

  // Decoder states; ARM waits for the level to be seen low before any press.
  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_HELD    = 2'd3
  } state_e;

  localparam int DEF_CNT_W         = 26;
  localparam int DEF_HOLD_CYCLES   = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;

endpackage
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_decoder
//  Description : Turns a debounced button level into press / release /
//                long-press / auto-repeat pulses plus a held level.
//                All outputs are registered: each pulse appears one cycle
//                after the level sample that causes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int CNT_W         = DEF_CNT_W,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic button_level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  // Terminal counts; the counter is cleared on reaching either, so it never wraps.
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  // Next-state, counter and event decode; release takes priority over terminal counts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      ST_ARM: begin
        if (!button_level) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (button_level) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end

      ST_PRESSED: begin
        if (!button_level) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (!button_level) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_ARM;
        cnt_d   = '0;
      end
    endcase

    // held is registered from the next state so it tracks HELD exactly.
    held_d = (state_d == ST_HELD);
  end

  // State, counter and output registers with synchronous reset into ARM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ARM;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_decoder
//  Description : Self-checking bench for button_event_decoder with a
//                behavioural event model, directed scenarios and a long
//                random level stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button_level = 1'b0;
  logic press, release_pulse, long_press, repeat_pulse, held;

  int total = 0;
  int bad   = 0;

  button_event_decoder #(
    .CNT_W(8),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_level(button_level),
    .press(press),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .repeat_pulse(repeat_pulse),
    .held(held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks whether the level has been seen low since reset,
  // whether a press is open, and how many high samples followed the press sample.
  bit started = 0;
  bit armed   = 0;
  bit active  = 0;
  int idx     = 0;
  bit e_press, e_rel, e_long, e_rep, e_held;
  bit open_evt = 0;
  int pcnt = 0, rcnt = 0, sup = 0;

  always @(posedge clk) begin
    e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
    if (reset) begin
      started = 1;
      armed   = 0;
      active  = 0;
      idx     = 0;
      if (open_evt) sup++;
      open_evt = 0;
    end else if (!active) begin
      if (!armed) begin
        if (!button_level) armed = 1;
      end else if (button_level) begin
        active  = 1;
        idx     = 0;
        e_press = 1;
      end
    end else begin
      if (!button_level) begin
        active = 0;
        e_rel  = 1;
      end else begin
        idx++;
        if (idx == HOLD) e_long = 1;
        else if (idx > HOLD && ((idx - HOLD) % REP) == 0) e_rep = 1;
      end
    end
    e_held = active && (idx >= HOLD);
  end

  // Per-cycle comparison against the model plus independent event-sequence checks.
  always @(negedge clk) begin
    if (started) begin
      chk("press", int'(press), int'(e_press));
      chk("release", int'(release_pulse), int'(e_rel));
      chk("long_press", int'(long_press), int'(e_long));
      chk("repeat_pulse", int'(repeat_pulse), int'(e_rep));
      chk("held", int'(held), int'(e_held));
      chk("onehot", int'(press) + int'(release_pulse) + int'(long_press) + int'(repeat_pulse) <= 1 ? 1 : 0, 1);
      if (press) begin
        chk("press_while_open", int'(open_evt), 0);
        open_evt = 1;
        pcnt++;
      end
      if (release_pulse) begin
        chk("release_without_press", int'(open_evt), 1);
        open_evt = 0;
        rcnt++;
      end
    end
  end

  task automatic cyc(input logic lv, input logic rst = 1'b0);
    button_level = lv;
    reset        = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int run;
    logic lv;

    // Reset state
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("rst_press", int'(press), 0);
    chk("rst_release", int'(release_pulse), 0);
    chk("rst_held", int'(held), 0);

    // Short press: three high samples then low
    cyc(1'b0);
    cyc(1'b1);
    chk("short_press", int'(press), 1);
    cyc(1'b1);
    cyc(1'b1);
    chk("short_no_long", int'(long_press), 0);
    cyc(1'b0);
    chk("short_release", int'(release_pulse), 1);

    // Long hold: 20 high samples
    cyc(1'b1);
    chk("hold_press", int'(press), 1);
    for (int k = 1; k < 20; k++) begin
      cyc(1'b1);
      chk("hold_long", int'(long_press), (k == 8) ? 1 : 0);
      chk("hold_repeat", int'(repeat_pulse), (k == 12 || k == 16) ? 1 : 0);
      chk("hold_held", int'(held), (k >= 8) ? 1 : 0);
    end
    cyc(1'b0);
    chk("hold_release", int'(release_pulse), 1);
    chk("hold_held_drop", int'(held), 0);

    // Release coinciding with the long-press terminal count
    cyc(1'b1);
    for (int k = 1; k <= 7; k++) cyc(1'b1);
    cyc(1'b0);
    chk("tie_release", int'(release_pulse), 1);
    chk("tie_no_long", int'(long_press), 0);
    cyc(1'b1);
    chk("tie_idle_press", int'(press), 1);
    cyc(1'b0);

    // Reset while held with level still high
    cyc(1'b1);
    for (int k = 1; k <= 8; k++) cyc(1'b1);
    chk("pre_reset_held", int'(held), 1);
    cyc(1'b1, 1'b1);
    chk("mid_reset_held", int'(held), 0);
    chk("mid_reset_press", int'(press), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1);
      chk("post_reset_no_press", int'(press), 0);
    end
    cyc(1'b0);
    chk("post_reset_no_release", int'(release_pulse), 0);
    cyc(1'b1);
    chk("post_reset_press", int'(press), 1);
    cyc(1'b0);

    // Random level stream with occasional resets
    lv  = 1'b0;
    run = 0;
    for (int i = 0; i < 100000; i++) begin
      if (run == 0) begin
        lv  = ~lv;
        run = int'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 30 : 6));
      end
      run--;
      cyc(lv, ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    chk("press_release_balance", pcnt, rcnt + sup + int'(open_evt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
